// File: rtl/color_expand.sv
// Reduced-depth RGB to 24-bit RGB expander: per-channel MSB bit replication behind
// a two-stage valid/ready pipeline, with depth changes latched at start of frame.
module color_expand (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [1:0]  selector,
    input  logic [2:0]  inputVal,
    input  logic [23:0] codeRGB,
    input  logic        sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] uptRGB,
    output logic        out_valid,
    input  logic        out_ready
);

    // Depth codes packed as {R,G,B} 3-bit fields; code c means depth k = c+1.
    logic [8:0]  pend_q, pend_d;
    logic [8:0]  act_q, act_d;
    logic [8:0]  k_in;
    logic [8:0]  s1_k_q;
    logic [23:0] s1_pix_q;
    logic        s1_valid_q;
    logic [23:0] upt_q;
    logic [23:0] expanded;
    logic        out_valid_q;
    logic        s2_adv;
    logic        accept;
    logic        frame_start;

    // Replicate the k valid bits from the MSB downwards to fill 8 bits.
    function automatic logic [7:0] expand_chan(input logic [7:0] c, input logic [2:0] code);
        logic [7:0] r;
        case (code)
            3'd0:    r = {8{c[0]}};
            3'd1:    r = {4{c[1:0]}};
            3'd2:    r = {c[2:0], c[2:0], c[2:1]};
            3'd3:    r = {2{c[3:0]}};
            3'd4:    r = {c[4:0], c[4:2]};
            3'd5:    r = {c[5:0], c[5:4]};
            3'd6:    r = {c[6:0], c[6]};
            default: r = c;
        endcase
        expand_chan = r;
    endfunction

    assign s2_adv      = !out_valid_q || out_ready;
    assign in_ready    = !s1_valid_q || s2_adv;
    assign accept      = in_valid && in_ready;
    assign frame_start = accept && sof;

    // Channel gi = 0 is R (top byte); field position mirrors the pixel byte order.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            localparam int FLD = 3 * (2 - gi);
            localparam int BYT = 8 * (2 - gi);
            logic write_ch;

            assign write_ch = select && ((selector == 2'(gi)) || (selector == 2'd3));
            // A write in the same cycle as an sof acceptance reaches act via pend_d.
            assign pend_d[FLD +: 3]   = write_ch ? inputVal : pend_q[FLD +: 3];
            assign act_d[FLD +: 3]    = frame_start ? pend_d[FLD +: 3] : act_q[FLD +: 3];
            assign k_in[FLD +: 3]     = sof ? pend_d[FLD +: 3] : act_q[FLD +: 3];
            assign expanded[BYT +: 8] = expand_chan(s1_pix_q[BYT +: 8], s1_k_q[FLD +: 3]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q      <= 9'h1FF;
            act_q       <= 9'h1FF;
            s1_k_q      <= 9'h1FF;
            s1_pix_q    <= 24'h000000;
            s1_valid_q  <= 1'b0;
            upt_q       <= 24'h000000;
            out_valid_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (accept) begin
                    s1_pix_q <= codeRGB;
                    s1_k_q   <= k_in;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    upt_q <= expanded;
                end
            end
        end
    end

    assign uptRGB    = upt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_color_expand.sv
// Self-checking bench for color_expand: directed scenarios plus a randomized run,
// checked against a scoreboard fed by a bit-level replication model.
module tb_color_expand;

    logic        clk = 1'b0;
    logic        reset;
    logic        select;
    logic [1:0]  selector;
    logic [2:0]  inputVal;
    logic [23:0] codeRGB;
    logic        sof;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] uptRGB;
    logic        out_valid;
    logic        out_ready;

    int compared   = 0;
    int mismatched = 0;

    int            pend_m [3];
    int            act_m  [3];
    logic [23:0]   exp_q  [$];
    logic          prev_stall = 1'b0;
    logic [23:0]   prev_upt   = 24'h0;

    color_expand dut (
        .clk       (clk),
        .reset     (reset),
        .select    (select),
        .selector  (selector),
        .inputVal  (inputVal),
        .codeRGB   (codeRGB),
        .sof       (sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .uptRGB    (uptRGB),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output bit i takes value bit (k-1) - ((7-i) mod k) of the low k bits.
    function automatic logic [7:0] ref_expand(input logic [7:0] b, input int k);
        logic [7:0] v;
        logic [7:0] r;
        v = b & 8'((1 << k) - 1);
        for (int i = 0; i < 8; i++) r[i] = v[(k - 1) - ((7 - i) % k)];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            pend_m[c] = 8;
            act_m[c]  = 8;
        end
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    // One clock of stimulus: drive at the falling edge, check shortly after, update the model.
    task automatic step(input logic sel, input logic [1:0] selr, input logic [2:0] val,
                        input logic [23:0] pix, input logic sf, input logic vld,
                        input logic ordy, output logic acc);
        logic [23:0] e;
        @(negedge clk);
        select = sel; selector = selr; inputVal = val;
        codeRGB = pix; sof = sf; in_valid = vld; out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(uptRGB), 32'(prev_upt));
        end
        chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
        if (exp_q.size() == 0) begin
            chk("no_spurious_out", 32'(out_valid), 32'd0);
        end else if (out_valid && ordy) begin
            e = exp_q.pop_front();
            chk("out_data", 32'(uptRGB), 32'(e));
        end
        if (sel) begin
            for (int c = 0; c < 3; c++)
                if (selr == 2'd3 || int'(selr) == c) pend_m[c] = int'(val) + 1;
        end
        acc = vld && in_ready;
        if (acc) begin
            if (sf) act_m = pend_m;
            exp_q.push_back({ref_expand(pix[23:16], act_m[0]),
                             ref_expand(pix[15:8],  act_m[1]),
                             ref_expand(pix[7:0],   act_m[2])});
        end
        prev_stall = out_valid && !ordy;
        prev_upt   = uptRGB;
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 2'd0, 3'd0, 24'h0, 1'b0, 1'b0, ordy, a);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 12 && exp_q.size() > 0; n++) idle(1'b1);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic        a;
        logic [23:0] bp [4];
        int          idx;
        int          budget;

        reset = 1'b0; select = 1'b0; selector = 2'd0; inputVal = 3'd0;
        codeRGB = 24'h0; sof = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        model_reset();

        // Reset state then passthrough with default depths
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_upt", 32'(uptRGB), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 2'd0, 3'd0, 24'h17C668, 1'b1, 1'b1, 1'b1, a);
        idle(1'b1);
        chk("lat_edge1", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("lat_edge2_valid", 32'(out_valid), 32'd1);
        chk("passthrough", 32'(uptRGB), 32'h17C668);

        // Replication values R k=3, G k=2, B k=5
        step(1'b1, 2'd0, 3'd2, 24'h0, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 2'd1, 3'd1, 24'h0, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 2'd2, 3'd4, 24'h0, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, 2'd0, 3'd0, {8'd5, 8'd2, 8'h13}, 1'b1, 1'b1, 1'b1, a);
        idle(1'b1);
        idle(1'b1);
        chk("replicate", 32'(uptRGB), 32'({8'd182, 8'd170, 8'd156}));

        // Depth 1 extremes, upper bits ignored
        step(1'b1, 2'd3, 3'd0, 24'h0, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, 2'd0, 3'd0, 24'h0100FF, 1'b1, 1'b1, 1'b1, a);
        idle(1'b1);
        idle(1'b1);
        chk("depth1", 32'(uptRGB), 32'h00FF00FF);

        // Write coinciding with sof is included (back to k=8), then mid-frame latch test
        step(1'b1, 2'd3, 3'd7, 24'h0A0B0C, 1'b1, 1'b1, 1'b1, a);
        step(1'b1, 2'd3, 3'd2, 24'h050505, 1'b0, 1'b1, 1'b1, a);
        idle(1'b1);
        chk("sof_bypass", 32'(uptRGB), 32'h0A0B0C);
        idle(1'b1);
        chk("latch_old_depth", 32'(uptRGB), 32'h050505);
        step(1'b0, 2'd0, 3'd0, 24'h050505, 1'b1, 1'b1, 1'b1, a);
        idle(1'b1);
        idle(1'b1);
        chk("latch_new_depth", 32'(uptRGB), 32'hB6B6B6);

        // Backpressure: 4 pixels, out_ready low for 5 cycles
        for (int i = 0; i < 4; i++) bp[i] = $urandom();
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 2'd0, 3'd0, bp[idx], 1'b0, idx < 4, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_frozen_first", 32'(uptRGB), 32'(exp_q[0]));
        budget = 0;
        while (idx < 4 && budget < 20) begin
            step(1'b0, 2'd0, 3'd0, bp[idx], 1'b0, 1'b1, 1'b1, a);
            if (a) idx++;
            budget++;
        end
        chk("bp_all_sent", 32'(idx), 32'd4);
        drain("bp_drain");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom() % 8) == 0, 2'($urandom()), 3'($urandom()), 24'($urandom()),
                 ($urandom() % 12) == 0, ($urandom() % 4) != 0, ($urandom() % 4) != 0, a);
        end
        drain("rand_drain");

        // Reset mid-stream: pending k=3 not latched, two pixels in flight
        step(1'b1, 2'd3, 3'd2, 24'h0, 1'b0, 1'b0, 1'b1, a);
        step(1'b0, 2'd0, 3'd0, 24'h123456, 1'b0, 1'b1, 1'b0, a);
        step(1'b0, 2'd0, 3'd0, 24'h654321, 1'b0, 1'b1, 1'b0, a);
        idle(1'b0);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        select = 1'b0; in_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_upt", 32'(uptRGB), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(1'b0, 2'd0, 3'd0, 24'h050505, 1'b1, 1'b1, 1'b1, a);
        idle(1'b1);
        idle(1'b1);
        chk("post_rst_passthru", 32'(uptRGB), 32'h050505);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
